// File: rtl/oric_tape_adc.sv
// oric_tape_adc: cassette input front end for the Oric core.
// Periodically runs one LTC2308 conversion over SPI. Each 12-bit sample
// drives a hysteresis comparator (tape bit) and an activity hold timer.
//
// Output strobe semantics: sample_valid is a one-cycle strobe with no
// backpressure. sample, dout and active change only in the cycle that
// sample_valid is high, and they hold their values until the next strobe.
module oric_tape_adc #(
  parameter int          CLK_RATE    = 50_000_000,
  parameter int          SAMPLE_RATE = 48_000,
  parameter int          SCK_DIV     = 2,
  parameter int          CONV_PULSE  = 2,
  parameter int          CONV_WAIT   = 80,
  parameter logic [5:0]  ADC_CFG     = 6'b100010,
  parameter logic [11:0] HIST_HI     = 12'd2200,
  parameter logic [11:0] HIST_LO     = 12'd1900,
  parameter logic [15:0] ACT_HOLD    = 16'd24000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        dout,
  output logic        active,
  output logic [2:0]  dbg_state
);

  // Sample period in clk cycles and counter widths.
  localparam int P      = CLK_RATE / SAMPLE_RATE;
  localparam int TW     = (P > 1) ? $clog2(P) : 1;
  localparam int CMAX_A = (CONV_PULSE > CONV_WAIT) ? CONV_PULSE : CONV_WAIT;
  localparam int CMAX   = (CMAX_A > 2 * SCK_DIV) ? CMAX_A : 2 * SCK_DIV;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(P - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_PULSE - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(CONV_WAIT - 1);
  localparam logic [CW-1:0] LOW_LAST   = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(2 * SCK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // A full transaction must fit inside one sample period, otherwise ticks
  // would be silently dropped every time.
  if (P <= CONV_PULSE + CONV_WAIT + 24 * SCK_DIV + 2) begin : g_rate_check
    $error("oric_tape_adc: sample period too short for one ADC transaction");
  end
  if (SCK_DIV < 1) begin : g_sck_check
    $error("oric_tape_adc: SCK_DIV must be at least 1");
  end

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [5:0]    r_cfg_sr;
  logic [11:0]   r_shift;
  logic          r_convst;
  logic          r_sck;
  logic          r_sdi;
  logic [11:0]   r_sample;
  logic          r_sample_valid;
  logic          r_dout;
  logic          r_active;
  logic [15:0]   r_act_cnt;
  logic          w_dout_next;
  logic          w_toggle;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Free-running sample period counter, 0..P-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Hysteresis decision on the freshly shifted-in sample; equal values hold.
  always_comb begin
    w_dout_next = r_dout;
    if (r_shift > HIST_HI) begin
      w_dout_next = 1'b1;
    end else if (r_shift < HIST_LO) begin
      w_dout_next = 1'b0;
    end
  end

  assign w_toggle = (w_dout_next != r_dout);

  // Conversion sequencer, SPI shifter, and registered sample/tape/activity outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_cfg_sr       <= '0;
      r_shift        <= '0;
      r_convst       <= 1'b0;
      r_sck          <= 1'b0;
      r_sdi          <= 1'b0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_dout         <= 1'b0;
      r_active       <= 1'b0;
      r_act_cnt      <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Ticks seen outside IDLE are simply lost.
          if (w_tick) begin
            r_state  <= S_CONV;
            r_convst <= 1'b1;
            r_cnt    <= '0;
          end
        end
        S_CONV: begin
          if (r_cnt == CONV_LAST) begin
            r_convst <= 1'b0;
            r_state  <= S_WAIT;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == WAIT_LAST) begin
            r_state  <= S_SHIFT;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_sdi    <= ADC_CFG[5];
            r_cfg_sr <= {ADC_CFG[4:0], 1'b0};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == LOW_LAST) begin
            // SCK rising edge: capture SDO, MSB first.
            r_sck   <= 1'b1;
            r_shift <= {r_shift[10:0], adc_sdo};
            r_cnt   <= r_cnt + 1'b1;
          end else if (r_cnt == HIGH_LAST) begin
            r_sck <= 1'b0;
            r_cnt <= '0;
            if (r_bit == 4'd11) begin
              r_state <= S_DONE;
              r_sdi   <= 1'b0;
            end else begin
              // Config bits run out after six shifts; zeros follow.
              r_bit    <= r_bit + 1'b1;
              r_sdi    <= r_cfg_sr[5];
              r_cfg_sr <= {r_cfg_sr[4:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_sample       <= r_shift;
          r_sample_valid <= 1'b1;
          r_dout         <= w_dout_next;
          if (w_toggle) begin
            r_act_cnt <= ACT_HOLD;
            r_active  <= (ACT_HOLD != 16'd0);
          end else if (r_act_cnt != 16'd0) begin
            r_act_cnt <= r_act_cnt - 16'd1;
            if (r_act_cnt == 16'd1) begin
              r_active <= 1'b0;
            end
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign adc_convst   = r_convst;
  assign adc_sck      = r_sck;
  assign adc_sdi      = r_sdi;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign dout         = r_dout;
  assign active       = r_active;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_oric_tape_adc.sv
// Bench for oric_tape_adc: LTC2308 behavioural model, directed samples,
// one task per feature with inline expected-value comparisons.
module tb_oric_tape_adc;

  localparam int P          = 1041;
  localparam int LAT        = 131;   // convst-high cycle to sample_valid cycle
  localparam int BOUND      = 3000;

  // Clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT with default parameters
  logic        adc_convst, adc_sck, adc_sdi;
  logic        adc_sdo = 1'b0;
  logic [11:0] sample;
  logic        sample_valid, dout, active;
  logic [2:0]  dbg_state;

  // Second DUT with a short activity hold; fed the same SDO stream
  logic        b_convst, b_sck, b_sdi;
  logic [11:0] b_sample;
  logic        b_valid, b_dout, b_active;
  logic [2:0]  b_state;

  oric_tape_adc u_dut (
    .clk(clk), .reset_n(reset_n),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .sample(sample), .sample_valid(sample_valid), .dout(dout), .active(active),
    .dbg_state(dbg_state)
  );

  oric_tape_adc #(.ACT_HOLD(16'd3)) u_act (
    .clk(clk), .reset_n(reset_n),
    .adc_convst(b_convst), .adc_sck(b_sck), .adc_sdi(b_sdi), .adc_sdo(adc_sdo),
    .sample(b_sample), .sample_valid(b_valid), .dout(b_dout), .active(b_active),
    .dbg_state(b_state)
  );

  int checks = 0;
  int errors = 0;

  // ADC model: samples pins mid-cycle, so it never races the DUT's clk edge.
  logic [11:0] adc_word = 12'h000;
  logic [11:0] m_word = 12'h000;
  int          m_idx = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          sck_rises = 0;
  int          per_min = 0;
  int          per_max = 0;
  logic [11:0] sdi_bits = 12'h000;
  logic        m_prev_convst = 1'b0;
  logic        m_prev_sck = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (adc_convst && !m_prev_convst) begin
      m_word    = adc_word;
      m_idx     = 0;
      adc_sdo   = adc_word[11];
      sck_rises = 0;
      sdi_bits  = 12'h000;
      per_min   = 9999;
      per_max   = 0;
    end
    if (adc_sck && !m_prev_sck) begin
      sdi_bits = {sdi_bits[10:0], adc_sdi};
      if (sck_rises > 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
      sck_rises = sck_rises + 1;
    end
    if (!adc_sck && m_prev_sck) begin
      m_idx = m_idx + 1;
      if (m_idx < 12) adc_sdo = m_word[11 - m_idx];
      else            adc_sdo = 1'b0;
    end
    m_prev_convst = adc_convst;
    m_prev_sck    = adc_sck;
  end

  // Driver: load the ADC word, then wait (bounded) for the next sample strobe.
  task automatic do_sample(input logic [11:0] w, output bit ok);
    adc_word = w;
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk); #1;
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Driver: count clk edges until adc_convst is seen high (bounded).
  task automatic wait_convst(output int n);
    n = 0;
    while (n < BOUND) begin
      @(posedge clk); n++; #1;
      if (adc_convst) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({adc_convst, adc_sck, adc_sdi, sample, sample_valid, dout, active, dbg_state} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {adc_convst, adc_sck, adc_sdi, sample, sample_valid, dout, active, dbg_state});
    end
    checks++;
    if ({b_convst, b_sck, b_sdi, b_sample, b_valid, b_dout, b_active, b_state} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs_b got %b exp 0", {b_convst, b_sck, b_sdi, b_sample, b_valid, b_dout, b_active, b_state});
    end
  endtask

  task automatic test_spi_capture;
    int n;
    int m;
    adc_word = 12'hA5C;
    reset_n = 1'b1;
    wait_convst(n);
    checks++;
    if (n !== P) begin
      errors++;
      $display("FAIL first_convst_cycle got %0d exp %0d", n, P);
    end
    m = 0;
    while (m < BOUND) begin
      @(posedge clk); m++; #1;
      if (sample_valid) break;
    end
    checks++;
    if (m !== LAT) begin
      errors++;
      $display("FAIL valid_latency got %0d exp %0d", m, LAT);
    end
    checks++;
    if (sample !== 12'hA5C) begin
      errors++;
      $display("FAIL spi_sample got %h exp a5c", sample);
    end
    checks++;
    if (sck_rises !== 12) begin
      errors++;
      $display("FAIL sck_rises got %0d exp 12", sck_rises);
    end
    checks++;
    if (sdi_bits !== 12'b100010_000000) begin
      errors++;
      $display("FAIL sdi_bits got %b exp 100010000000", sdi_bits);
    end
    checks++;
    if (per_min !== 4 || per_max !== 4) begin
      errors++;
      $display("FAIL sck_period got min %0d max %0d exp 4", per_min, per_max);
    end
    checks++;
    if ({dout, active, b_dout, b_active} !== 4'b1111) begin
      errors++;
      $display("FAIL first_sample_flags got %b exp 1111", {dout, active, b_dout, b_active});
    end
    @(posedge clk); #1;
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_width got %b exp 0", sample_valid);
    end
  endtask

  task automatic test_hysteresis;
    logic [11:0] w_tab [6] = '{12'd1000, 12'd2000, 12'd2201, 12'd2000, 12'd1899, 12'd1900};
    logic        d_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_sample(w_tab[i], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL hyst_timeout[%0d] got no sample_valid exp strobe", i);
      end
      checks++;
      if ({sample, dout, b_dout, b_active} !== {w_tab[i], d_tab[i], d_tab[i], 1'b1}) begin
        errors++;
        $display("FAIL hyst[%0d] got sample %0d dout %b dout_b %b active_b %b exp %0d %b %b 1",
                 i, sample, dout, b_dout, b_active, w_tab[i], d_tab[i], d_tab[i]);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [11:0] w_tab [4] = '{12'hFFF, 12'd2200, 12'h000, 12'd1900};
    logic        d_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      do_sample(w_tab[i], ok);
      checks++;
      if (!ok || {sample, dout, b_dout} !== {w_tab[i], d_tab[i], d_tab[i]}) begin
        errors++;
        $display("FAIL bound[%0d] got ok %b sample %h dout %b dout_b %b exp %h %b",
                 i, ok, sample, dout, b_dout, w_tab[i], d_tab[i]);
      end
    end
  endtask

  task automatic test_activity;
    // Hold counter of u_act is 2 on entry (last toggle two samples ago).
    logic [11:0] w_tab [10] = '{12'd1000, 12'd1000, 12'd1000, 12'd3000, 12'd3000,
                                12'd3000, 12'd100, 12'd100, 12'd100, 12'd100};
    logic        d_tab [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        a_tab [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit ok;
    for (int i = 0; i < 10; i++) begin
      do_sample(w_tab[i], ok);
      checks++;
      if (!ok || {b_dout, b_active, active} !== {d_tab[i], a_tab[i], 1'b1}) begin
        errors++;
        $display("FAIL act[%0d] got ok %b dout_b %b active_b %b active %b exp %b %b 1",
                 i, ok, b_dout, b_active, active, d_tab[i], a_tab[i]);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    int n;
    bit ok;
    adc_word = 12'hABC;
    wait_convst(n);
    repeat (88) @(posedge clk);
    #1;
    checks++;
    if ({dbg_state, adc_sck, active} !== {3'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_state got state %0d sck %b active %b exp 3 1 1", dbg_state, adc_sck, active);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({adc_convst, adc_sck, adc_sdi, sample, sample_valid, dout, active, dbg_state} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {adc_convst, adc_sck, adc_sdi, sample, sample_valid, dout, active, dbg_state});
    end
    repeat (3) @(posedge clk);
    #1;
    adc_word = 12'h123;
    reset_n = 1'b1;
    wait_convst(n);
    checks++;
    if (n !== P) begin
      errors++;
      $display("FAIL restart_convst_cycle got %0d exp %0d", n, P);
    end
    do_sample(12'h123, ok);
    checks++;
    if (!ok || {sample, dout, active, b_active} !== {12'h123, 3'b000}) begin
      errors++;
      $display("FAIL post_reset_sample got ok %b sample %h dout %b active %b active_b %b exp 123 0 0 0",
               ok, sample, dout, active, b_active);
    end
  endtask

  task automatic test_tick_rate;
    int n;
    int w;
    int pulses;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      w = 0;
      while (n < BOUND) begin
        @(posedge clk); n++; #1;
        if (adc_convst) w++;
        if (sample_valid) break;
      end
      checks++;
      if (n !== P || w !== 2) begin
        errors++;
        $display("FAIL tick_spacing[%0d] got period %0d convst_width %0d exp %0d 2", k, n, w, P);
      end
    end
    pulses = 0;
    for (int c = 0; c < 5 * P; c++) begin
      @(posedge clk); #1;
      if (sample_valid) pulses++;
    end
    checks++;
    if (pulses !== 5) begin
      errors++;
      $display("FAIL valid_count got %0d exp 5", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_spi_capture();
    test_hysteresis();
    test_boundaries();
    test_activity();
    test_reset_mid_shift();
    test_tick_rate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oric_tape_adc.md
# oric_tape_adc

Cassette-input front end for the Oric core. Periodically converts the analogue tape signal with the LTC2308 ADC on the I/O board over SPI. Turns each 12-bit sample into a clean tape bit with a hysteresis comparator, and reports signal activity. Outputs: `dout` feeds the ULA/VIA tape input (`K7_TAPEIN`), and `active` is ORed into `LED_USER`.

## Interface
Parameters:
- `CLK_RATE`, 50_000_000: `clk` frequency in Hz.
- `SAMPLE_RATE`, 48_000: conversions per second.
- `SCK_DIV`, 2: `clk` cycles per SCK half-period. Must be ≥1.
- `CONV_PULSE`, 2: CONVST high time, in `clk` cycles.
- `CONV_WAIT`, 80: wait after the CONVST falling edge before shifting. Must be ≥1.6 µs.
- `ADC_CFG`, 6'b100010: LTC2308 config word sent MSB-first. Default is single-ended, CH0, unipolar, no sleep.
- `HIST_HI`, 12'd2200: rising threshold.
- `HIST_LO`, 12'd1900: falling threshold.
- `ACT_HOLD`, 16'd24000: samples without a `dout` toggle before `active` drops.

Ports:
- `clk`, in, 1: system clock, all logic.
- `reset_n`, in, 1: asynchronous active-low reset.
- `adc_convst`, out, 1: ADC conversion start.
- `adc_sck`, out, 1: SPI clock; idles low.
- `adc_sdi`, out, 1: config bits to ADC.
- `adc_sdo`, in, 1: conversion data from ADC.
- `sample`, out, 12: last captured sample.
- `sample_valid`, out, 1: one-cycle strobe when `sample` updates.
- `dout`, out, 1: hysteresis tape bit.
- `active`, out, 1: tape signal activity.

## Operation
- **Reset:** while `reset_n`=0, all outputs, the FSM, the tick counter and the activity counter are 0. FSM is in IDLE.
- **Tick counter:**
  - Counts 0..P−1, where P = CLK_RATE/SAMPLE_RATE (integer division; 1041 at defaults). Wraps to 0.
  - A tick is generated when count = P−1.
  - Requirement: P > CONV_PULSE + CONV_WAIT + 24·SCK_DIV + 2. The implementation enforces this with an elaboration check.
- **FSM states:** IDLE → CONV → WAIT → SHIFT → DONE → IDLE.
  - **IDLE:** on tick, go to CONV. A tick arriving in any other state is dropped (not queued).
  - **CONV:** `adc_convst`=1 for CONV_PULSE cycles, then 0, then go to WAIT.
  - **WAIT:** hold for CONV_WAIT cycles, then go to SHIFT.
  - **SHIFT:** 12 SCK periods, bit index k = 0..11.
    - Low phase: SCK_DIV cycles. `adc_sdi` = ADC_CFG[5−k] for k<6, else 0.
    - High phase: SCK_DIV cycles.
    - `adc_sdo` is registered into the shift register on the `clk` edge where `adc_sck` goes 0→1. Capture is MSB first (D11 first).
    - After the 12th high phase, `adc_sck` returns to 0 and the FSM goes to DONE.
  - **DONE:** one cycle. `sample` ← shift register, `sample_valid`=1, comparator and activity logic update. Then go to IDLE.
- **Hysteresis** (evaluated in DONE on the new sample):
  - If sample > HIST_HI, `dout`=1.
  - Else if sample < HIST_LO, `dout`=0.
  - Otherwise `dout` holds.
  - Comparisons are unsigned 12-bit.
- **Activity:**
  - If `dout` toggles in DONE, the 16-bit counter is loaded with ACT_HOLD and `active`=1.
  - Otherwise, if counter ≠ 0, it decrements once per sample. `active`=0 when it reaches 0.
  - The counter saturates at 0 (no wrap).
- **Reset mid-transaction:** outputs clear immediately (asynchronously). After release, the FSM restarts from IDLE and the partial sample is discarded.

## Timing
- All outputs are registered on `clk`. There are no combinational paths from `adc_sdo` to outputs.
- Latency from tick to CONVST high: 1 cycle.
- Latency from tick to `sample_valid`: 1 + CONV_PULSE + CONV_WAIT + 24·SCK_DIV + 1 cycles, which is 132 at defaults.
- `sample_valid` is high exactly 1 cycle per accepted tick. `sample`, `dout` and `active` change only in that same cycle.
- SCK frequency = CLK_RATE/(2·SCK_DIV), i.e. 12.5 MHz at defaults. `adc_sdi` is stable for the whole high phase.
- First tick falls P cycles after `reset_n` rises.

## Test plan
- **Reset:** assert `reset_n`=0 mid-SHIFT → all outputs 0 within the same cycle. After release, the first `adc_convst` rise is at cycle P (1041) and the previous partial data never appears on `sample`.
- **SPI capture:** ADC model returns 12'hA5C → `sample`=12'hA5C with `sample_valid` 132 cycles after the tick. The model sees config bits 1,0,0,0,1,0, then zeros; exactly 12 SCK rising edges; SCK period 4 cycles.
- **Hysteresis:** sample sequence 1000, 2000, 2201, 2000, 1899, 1900 → `dout` = 0, 0, 1, 1, 0, 0.
- **Activity:** ACT_HOLD=3 with one toggle, then constant samples → `active` goes 1 on the toggle sample and returns to 0 on the 3rd following sample. A toggle while the counter is 1 reloads it to 3.
- **Tick rate:** run 10 ms → exactly 480 `sample_valid` pulses, each spaced 1041 cycles apart, with CONVST width = 2 cycles each.
- **Boundaries:** sample = 12'hFFF and 12'h000 → `dout` 1 then 0. A sample exactly equal to HIST_HI or HIST_LO holds `dout`.
